// File: rtl/spi_mem_slave_burst.sv
// SPI slave with an integrated memory-port master.
//
// Framed commands arrive on MOSI and are decoded into accesses on a
// single-port synchronous RAM that sits outside this block. Write frames can
// continue as auto-incrementing bursts. Read frames stream words out on MISO
// with no gap between words, using a one-word prefetch buffer.
//
// Frame layout after SS_n falls:
//   mode bit, then cmd[1:0], then payload[DATA_W-1:0], all MSB first.
//   mode 0: cmd 00 loads the write address, cmd 01 writes a word.
//   mode 1: cmd 10 loads the read address, cmd 11 starts a read.
//
// Ports:
//   clk        single clock; it is also the SPI bit clock (rising edge)
//   rst_n      synchronous active-low reset
//   SS_n       slave select, active low
//   MOSI       serial data in, MSB first
//   MISO       serial data out, MSB first
//   mem_addr   RAM address
//   mem_wdata  RAM write data
//   mem_we     one-cycle RAM write strobe
//   mem_re     one-cycle RAM read strobe
//   mem_rdata  RAM read data, valid one cycle after mem_re
//   frame_err  one-cycle pulse on a malformed or aborted frame
module spi_mem_slave_burst #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter bit BURST_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              frame_err
);

  localparam int FRAME_W = DATA_W + 2;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int OCNT_W  = $clog2(DATA_W + 1);

  localparam logic [CNT_W-1:0]  LAST_FULL  = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0]  LAST_BURST = CNT_W'(DATA_W - 1);
  localparam logic [OCNT_W-1:0] WORD_DONE  = OCNT_W'(DATA_W);

  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    CHK_CMD   = 3'b001,
    WRITE     = 3'b010,
    READ_ADD  = 3'b011,
    READ_DATA = 3'b100,
    WAIT_SS   = 3'b101
  } state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [FRAME_W-2:0]  shreg, shreg_n;
  logic                frame_done, frame_done_n;
  logic                burst, burst_n;
  logic [ADDR_W-1:0]   wr_addr, wr_addr_n;
  logic [ADDR_W-1:0]   rd_addr, rd_addr_n;
  logic                addr_loaded, addr_loaded_n;
  logic [DATA_W-1:0]   tx, tx_n;
  logic [OCNT_W-1:0]   out_cnt, out_cnt_n;
  logic                out_act, out_act_n;
  logic                first_word, first_word_n;
  logic [1:0]          rd_pipe, rd_pipe_n;
  logic [DATA_W-1:0]   pf_buf, pf_buf_n;
  logic                miso_n;
  logic [ADDR_W-1:0]   mem_addr_n;
  logic [DATA_W-1:0]   mem_wdata_n;
  logic                mem_we_n, mem_re_n, frame_err_n;

  logic [FRAME_W-1:0]  sample;
  logic [1:0]          cmd;
  logic [DATA_W-1:0]   payload;
  logic                last_bit;
  logic                load_now;
  logic [DATA_W-1:0]   load_val;

  // State and datapath register. Every register simply takes its next value
  // from the decode process below, except under reset, which wins over
  // everything including a transfer in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      shreg       <= '0;
      frame_done  <= 1'b0;
      burst       <= 1'b0;
      wr_addr     <= '0;
      rd_addr     <= '0;
      addr_loaded <= 1'b0;
      tx          <= '0;
      out_cnt     <= '0;
      out_act     <= 1'b0;
      first_word  <= 1'b0;
      rd_pipe     <= '0;
      pf_buf      <= '0;
      MISO        <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
      mem_re      <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      shreg       <= shreg_n;
      frame_done  <= frame_done_n;
      burst       <= burst_n;
      wr_addr     <= wr_addr_n;
      rd_addr     <= rd_addr_n;
      addr_loaded <= addr_loaded_n;
      tx          <= tx_n;
      out_cnt     <= out_cnt_n;
      out_act     <= out_act_n;
      first_word  <= first_word_n;
      rd_pipe     <= rd_pipe_n;
      pf_buf      <= pf_buf_n;
      MISO        <= miso_n;
      mem_addr    <= mem_addr_n;
      mem_wdata   <= mem_wdata_n;
      mem_we      <= mem_we_n;
      mem_re      <= mem_re_n;
      frame_err   <= frame_err_n;
    end
  end

  // Next-state and next-output decode.
  // frame_done records that a complete first frame has been sampled, so a
  // later SS_n rise (end of a burst, or leaving WAIT_SS) is not an error.
  // rd_pipe tracks the two-cycle RAM read latency: bit 1 set means mem_rdata
  // holds the word requested two edges ago. The first read result goes
  // straight to the output shifter; later ones land in the prefetch buffer.
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    shreg_n       = shreg;
    frame_done_n  = frame_done;
    burst_n       = burst;
    wr_addr_n     = wr_addr;
    rd_addr_n     = rd_addr;
    addr_loaded_n = addr_loaded;
    tx_n          = tx;
    out_cnt_n     = out_cnt;
    out_act_n     = out_act;
    first_word_n  = first_word;
    rd_pipe_n     = {rd_pipe[0], 1'b0};
    pf_buf_n      = pf_buf;
    miso_n        = 1'b0;
    mem_addr_n    = mem_addr;
    mem_wdata_n   = mem_wdata;
    mem_we_n      = 1'b0;
    mem_re_n      = 1'b0;
    frame_err_n   = 1'b0;
    load_now      = 1'b0;
    load_val      = mem_rdata;

    sample   = {shreg, MOSI};
    cmd      = sample[FRAME_W-1 -: 2];
    payload  = sample[DATA_W-1:0];
    last_bit = (cnt == (burst ? LAST_BURST : LAST_FULL));

    if (state != IDLE && SS_n) begin
      // Deselect ends everything; a partial first frame is an error and any
      // read still in flight is forgotten.
      state_n     = IDLE;
      frame_err_n = !frame_done;
      rd_pipe_n   = '0;
      out_act_n   = 1'b0;
      if (state == READ_DATA) addr_loaded_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!SS_n) begin
            state_n      = CHK_CMD;
            cnt_n        = '0;
            frame_done_n = 1'b0;
            burst_n      = 1'b0;
            out_act_n    = 1'b0;
          end
        end

        CHK_CMD: begin
          if (!MOSI)            state_n = WRITE;
          else if (addr_loaded) state_n = READ_DATA;
          else                  state_n = READ_ADD;
        end

        WRITE: begin
          shreg_n = sample[FRAME_W-2:0];
          cnt_n   = cnt + CNT_W'(1);
          if (last_bit) begin
            cnt_n        = '0;
            frame_done_n = 1'b1;
            if (burst || cmd == 2'b01) begin
              mem_we_n    = 1'b1;
              mem_addr_n  = wr_addr;
              mem_wdata_n = payload;
              if (BURST_EN) begin
                wr_addr_n = wr_addr + ADDR_W'(1);
                burst_n   = 1'b1;
              end else begin
                state_n = WAIT_SS;
              end
            end else if (cmd == 2'b00) begin
              wr_addr_n = payload[ADDR_W-1:0];
              state_n   = WAIT_SS;
            end else begin
              frame_err_n = 1'b1;
              state_n     = WAIT_SS;
            end
          end
        end

        READ_ADD: begin
          if (!frame_done) begin
            shreg_n = sample[FRAME_W-2:0];
            cnt_n   = cnt + CNT_W'(1);
            if (last_bit) begin
              frame_done_n = 1'b1;
              if (cmd == 2'b10) begin
                rd_addr_n     = payload[ADDR_W-1:0];
                addr_loaded_n = 1'b1;
              end else begin
                frame_err_n = 1'b1;
                state_n     = WAIT_SS;
              end
            end
          end
        end

        READ_DATA: begin
          if (!frame_done) begin
            shreg_n = sample[FRAME_W-2:0];
            cnt_n   = cnt + CNT_W'(1);
            if (last_bit) begin
              frame_done_n = 1'b1;
              if (cmd == 2'b11) begin
                mem_re_n     = 1'b1;
                mem_addr_n   = rd_addr;
                rd_pipe_n    = 2'b01;
                first_word_n = 1'b1;
              end else begin
                frame_err_n = 1'b1;
                state_n     = WAIT_SS;
              end
            end
          end else begin
            if (rd_pipe[1] && first_word) begin
              load_now = 1'b1;
              load_val = mem_rdata;
            end else if (out_act && out_cnt == WORD_DONE) begin
              if (BURST_EN) begin
                load_now = 1'b1;
                load_val = pf_buf;
              end else begin
                out_act_n = 1'b0;
              end
            end else if (out_act) begin
              miso_n    = tx[DATA_W-1];
              tx_n      = {tx[DATA_W-2:0], 1'b0};
              out_cnt_n = out_cnt + OCNT_W'(1);
            end
            if (rd_pipe[1] && !first_word) pf_buf_n = mem_rdata;
          end
        end

        WAIT_SS: begin
          state_n = WAIT_SS;
        end

        default: begin
          state_n = IDLE;
        end
      endcase
    end

    // Start shifting a fresh word: its MSB goes out on this edge and, in
    // burst mode, the following word is requested at the same time.
    if (load_now) begin
      miso_n       = load_val[DATA_W-1];
      tx_n         = {load_val[DATA_W-2:0], 1'b0};
      out_cnt_n    = OCNT_W'(1);
      out_act_n    = 1'b1;
      first_word_n = 1'b0;
      if (BURST_EN) begin
        mem_re_n   = 1'b1;
        mem_addr_n = rd_addr + ADDR_W'(1);
        rd_addr_n  = rd_addr + ADDR_W'(1);
        rd_pipe_n  = 2'b01;
      end
    end
  end

endmodule

// File: tb/tb_spi_mem_slave_burst.sv
// Directed testbench for spi_mem_slave_burst (DATA_W=8, ADDR_W=8, burst on).
// Inputs are driven on the falling edge and outputs sampled on the falling
// edge, so the DUT always sees stable values at its rising edge.
module tb_spi_mem_slave_burst;

  localparam int DW = 8;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          SS_n;
  logic          MOSI;
  logic          MISO;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [DW-1:0] mem_rdata;
  logic          frame_err;

  logic [DW-1:0] ram [256];

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] we_addr_q [$];
  logic [DW-1:0] we_data_q [$];
  logic [AW-1:0] re_addr_q [$];
  int            err_pulses = 0;
  int            overlap = 0;

  always #5 clk = ~clk;

  spi_mem_slave_burst #(.DATA_W(DW), .ADDR_W(AW), .BURST_EN(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .frame_err (frame_err)
  );

  // External single-port synchronous RAM.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  // Log every strobe cycle so tests can count exact pulse widths.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      we_addr_q.push_back(mem_addr);
      we_data_q.push_back(mem_wdata);
    end
    if (mem_re === 1'b1) re_addr_q.push_back(mem_addr);
    if (frame_err === 1'b1) err_pulses++;
    if (mem_we === 1'b1 && mem_re === 1'b1) overlap++;
  end

  task automatic clear_log();
    we_addr_q.delete();
    we_data_q.delete();
    re_addr_q.delete();
    err_pulses = 0;
  endtask

  task automatic pad_log(input int n);
    while (we_addr_q.size() < n) begin
      we_addr_q.push_back('x);
      we_data_q.push_back('x);
    end
    while (re_addr_q.size() < n) re_addr_q.push_back('x);
  endtask

  // Select the slave and present the mode bit for the CHK_CMD edge.
  task automatic start_frame(input logic mode);
    @(negedge clk);
    SS_n = 1'b0;
    MOSI = mode;
    @(negedge clk);
  endtask

  task automatic shift_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      MOSI = v[i];
    end
  endtask

  task automatic end_frame();
    @(negedge clk);
    SS_n = 1'b1;
    MOSI = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    SS_n  = 1'b1;
    MOSI  = 1'b0;
    repeat (2) begin
      @(negedge clk);
      SS_n = ~SS_n;
      MOSI = ~MOSI;
    end
    @(negedge clk);
    checks++;
    if ({MISO, mem_we, mem_re, frame_err} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b expected 0000", {MISO, mem_we, mem_re, frame_err});
    end
    checks++;
    if ({mem_addr, mem_wdata} !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_mem_bus: got %h expected 0000", {mem_addr, mem_wdata});
    end
    SS_n  = 1'b1;
    MOSI  = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    clear_log();
    start_frame(1'b0); shift_bits({6'd0, 2'b00, 8'h33}, 10); end_frame();
    start_frame(1'b0); shift_bits({6'd0, 2'b01, 8'h44}, 10); end_frame();
    checks++;
    if (we_addr_q.size() !== 1) begin
      errors++;
      $display("[TB] FAIL reset_first_write_count: got %0d expected 1", we_addr_q.size());
    end
    pad_log(1);
    checks++;
    if ({we_addr_q[0], we_data_q[0]} !== 16'h3344) begin
      errors++;
      $display("[TB] FAIL reset_first_write: got %h expected 3344", {we_addr_q[0], we_data_q[0]});
    end
  endtask

  task automatic test_single_write();
    clear_log();
    start_frame(1'b0); shift_bits({6'd0, 2'b00, 8'h05}, 10); end_frame();
    start_frame(1'b0); shift_bits({6'd0, 2'b01, 8'h25}, 10);
    @(negedge clk);
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'h05, 8'h25}) begin
      errors++;
      $display("[TB] FAIL single_write_edge: got we=%b addr=%h data=%h expected we=1 addr=05 data=25",
               mem_we, mem_addr, mem_wdata);
    end
    SS_n = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_write_width: got mem_we=%b expected 0", mem_we);
    end
    @(negedge clk);
    checks++;
    if (we_addr_q.size() !== 1 || err_pulses !== 0) begin
      errors++;
      $display("[TB] FAIL single_write_count: got writes=%0d errs=%0d expected 1 and 0",
               we_addr_q.size(), err_pulses);
    end
  endtask

  task automatic test_burst_write_wrap();
    clear_log();
    start_frame(1'b0); shift_bits({6'd0, 2'b00, 8'hFE}, 10); end_frame();
    start_frame(1'b0);
    shift_bits({6'd0, 2'b01, 8'hA1}, 10);
    shift_bits({8'd0, 8'hB2}, 8);
    shift_bits({8'd0, 8'hC3}, 8);
    end_frame();
    checks++;
    if (we_addr_q.size() !== 3) begin
      errors++;
      $display("[TB] FAIL burst_write_count: got %0d expected 3", we_addr_q.size());
    end
    pad_log(3);
    checks++;
    if ({we_addr_q[0], we_data_q[0], we_addr_q[1], we_data_q[1], we_addr_q[2], we_data_q[2]}
        !== 48'hFEA1_FFB2_00C3) begin
      errors++;
      $display("[TB] FAIL burst_write_data: got %h expected fea1ffb200c3",
               {we_addr_q[0], we_data_q[0], we_addr_q[1], we_data_q[1], we_addr_q[2], we_data_q[2]});
    end
  endtask

  task automatic test_burst_read();
    logic [15:0] rx;
    rx = '0;
    start_frame(1'b0); shift_bits({6'd0, 2'b00, 8'h05}, 10); end_frame();
    start_frame(1'b0);
    shift_bits({6'd0, 2'b01, 8'h25}, 10);
    shift_bits({8'd0, 8'h3C}, 8);
    end_frame();
    clear_log();
    start_frame(1'b1); shift_bits({6'd0, 2'b10, 8'h05}, 10); end_frame();
    checks++;
    if (re_addr_q.size() !== 0 || err_pulses !== 0) begin
      errors++;
      $display("[TB] FAIL read_addr_frame: got reads=%0d errs=%0d expected 0 and 0",
               re_addr_q.size(), err_pulses);
    end
    start_frame(1'b1); shift_bits({6'd0, 2'b11, 8'h00}, 10);
    MOSI = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_re, mem_addr} !== {1'b1, 8'h05}) begin
      errors++;
      $display("[TB] FAIL read_first_re: got re=%b addr=%h expected re=1 addr=05", mem_re, mem_addr);
    end
    @(negedge clk);
    checks++;
    if (MISO !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read_latency_gap: got MISO=%b expected 0", MISO);
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      rx[15-k] = MISO;
    end
    end_frame();
    checks++;
    if (rx !== 16'h253C) begin
      errors++;
      $display("[TB] FAIL read_miso_stream: got %h expected 253c", rx);
    end
    checks++;
    if (re_addr_q.size() !== 4) begin
      errors++;
      $display("[TB] FAIL read_re_count: got %0d expected 4", re_addr_q.size());
    end
    pad_log(4);
    checks++;
    if ({re_addr_q[0], re_addr_q[1], re_addr_q[2], re_addr_q[3]} !== 32'h05060708) begin
      errors++;
      $display("[TB] FAIL read_re_addrs: got %h expected 05060708",
               {re_addr_q[0], re_addr_q[1], re_addr_q[2], re_addr_q[3]});
    end
    checks++;
    if (MISO !== 1'b0 || err_pulses !== 0) begin
      errors++;
      $display("[TB] FAIL read_end: got MISO=%b errs=%0d expected 0 and 0", MISO, err_pulses);
    end
  endtask

  task automatic test_bad_command();
    clear_log();
    start_frame(1'b0); shift_bits({6'd0, 2'b11, 8'h12}, 10);
    @(negedge clk);
    checks++;
    if ({frame_err, mem_we, mem_re} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL bad_cmd_edge: got err/we/re=%b expected 100", {frame_err, mem_we, mem_re});
    end
    SS_n = 1'b1;
    @(negedge clk);
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bad_cmd_width: got frame_err=%b expected 0", frame_err);
    end
    @(negedge clk);
    checks++;
    if (err_pulses !== 1 || we_addr_q.size() !== 0 || re_addr_q.size() !== 0) begin
      errors++;
      $display("[TB] FAIL bad_cmd_effects: got errs=%0d writes=%0d reads=%0d expected 1 0 0",
               err_pulses, we_addr_q.size(), re_addr_q.size());
    end
    clear_log();
    start_frame(1'b0); shift_bits({6'd0, 2'b00, 8'h40}, 10); end_frame();
    start_frame(1'b0); shift_bits({6'd0, 2'b01, 8'h9D}, 10); end_frame();
    pad_log(1);
    checks++;
    if ({we_addr_q[0], we_data_q[0]} !== 16'h409D || err_pulses !== 0) begin
      errors++;
      $display("[TB] FAIL bad_cmd_recovery: got %h errs=%0d expected 409d errs=0",
               {we_addr_q[0], we_data_q[0]}, err_pulses);
    end
  endtask

  task automatic test_abort();
    clear_log();
    start_frame(1'b0); shift_bits(16'b01010, 5); end_frame();
    checks++;
    if (err_pulses !== 1 || we_addr_q.size() !== 0) begin
      errors++;
      $display("[TB] FAIL abort_frame: got errs=%0d writes=%0d expected 1 and 0",
               err_pulses, we_addr_q.size());
    end
  endtask

  task automatic test_reset_mid_read();
    clear_log();
    start_frame(1'b1); shift_bits({6'd0, 2'b10, 8'h05}, 10); end_frame();
    start_frame(1'b1); shift_bits({6'd0, 2'b11, 8'h00}, 10);
    MOSI = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (MISO !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_read_bit5: got MISO=%b expected 1", MISO);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({MISO, mem_re} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL mid_read_reset: got MISO/re=%b expected 00", {MISO, mem_re});
    end
    SS_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_log();
    start_frame(1'b1); shift_bits({6'd0, 2'b11, 8'h00}, 10); end_frame();
    checks++;
    if (err_pulses !== 1 || re_addr_q.size() !== 0) begin
      errors++;
      $display("[TB] FAIL addr_loaded_cleared: got errs=%0d reads=%0d expected 1 and 0",
               err_pulses, re_addr_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_burst_write_wrap();
    test_burst_read();
    test_bad_command();
    test_abort();
    test_reset_mid_read();
    checks++;
    if (overlap !== 0) begin
      errors++;
      $display("[TB] FAIL strobe_overlap: got %0d cycles expected 0", overlap);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_mem_slave_burst.md
Name: spi_mem_slave_burst

Overview:
- Parametrised SPI slave with an integrated memory-port master. It decodes framed commands on MOSI and drives a single-port synchronous RAM directly.
- Generalises the fixed 8-bit address/write/read slave to configurable data and address widths.
- Adds auto-incrementing burst writes, and gapless burst reads through a one-word prefetch buffer.
- Sits between the chip pins (SS_n/MOSI/MISO) and the RAM; the RAM is external to this block.

Parameters:
- DATA_W, 8: payload and memory word width; must be >= 4.
- ADDR_W, 8: memory address width, <= DATA_W; the address is taken from payload[ADDR_W-1:0].
- BURST_EN, 1: 1 enables address auto-increment and burst continuation; 0 gives single-word frames only.

Ports:
- clk  in  1  single clock; also the SPI bit clock. All sampling and driving happens on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- SS_n  in  1  slave select, active low.
- MOSI  in  1  serial data in, MSB first.
- MISO  out  1  serial data out, MSB first.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_we  out  1  one-cycle write strobe.
- mem_re  out  1  one-cycle read strobe.
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_re.
- frame_err  out  1  one-cycle pulse on a malformed or aborted frame.

Behaviour:
- Reset (rst_n low at a rising edge):
  - MISO, mem_we, mem_re and frame_err go to 0; mem_addr and mem_wdata go to 0.
  - wr_addr, rd_addr and the addr_loaded flag are cleared; state goes to IDLE.
  - Reset overrides everything, including a transfer in progress.
- State encoding: IDLE=000, CHK_CMD=001, WRITE=010, READ_ADD=011, READ_DATA=100, WAIT_SS=101.
- IDLE: when SS_n is sampled low, go to CHK_CMD.
- CHK_CMD: the mode bit is sampled on MOSI.
  - 0 -> WRITE.
  - 1 with addr_loaded=0 -> READ_ADD.
  - 1 with addr_loaded=1 -> READ_DATA.
- Frame: the next DATA_W+2 edges sample cmd[1:0] followed by the payload, MSB first. Edge N is the one that samples the last bit.
- WRITE state:
  - cmd=00: wr_addr <= payload. No memory access.
  - cmd=01: on edge N, mem_we=1, mem_addr=wr_addr, mem_wdata=payload, held for exactly one cycle.
  - Burst write (BURST_EN=1): after every write, wr_addr <= wr_addr+1. While SS_n stays low, each further DATA_W bits (no cmd prefix) form another write with the same one-cycle timing.
  - BURST_EN=0: bits after the first write are ignored until SS_n rises.
- READ_ADD state:
  - cmd=10: rd_addr <= payload and addr_loaded <= 1 on edge N.
  - Then wait in state for SS_n high.
- READ_DATA state: cmd must be 11; the payload is don't-care.
  - Edge N: mem_re=1, mem_addr=rd_addr.
  - Edge N+1: mem_rdata is valid.
  - Edge N+2: capture into the shift register. MISO shows bit DATA_W-1 from edge N+2, then one bit per edge; the LSB appears at edge N+1+DATA_W.
  - Prefetch (BURST_EN=1): at edge N+2, mem_re is issued for rd_addr+1 and the result is held in the prefetch buffer.
  - After the LSB, the buffered word's MSB appears on the very next edge (no gap). The next prefetch is issued at the same edge, and rd_addr advances once per word.
- End of read: addr_loaded clears when SS_n rises while in READ_DATA.
- Address wrap: addresses wrap from 2^ADDR_W-1 to 0 silently.
- Command mismatch (cmd illegal for the current state):
  - frame_err pulses for one cycle after edge N.
  - No mem_we, no mem_re, no address update.
  - Go to WAIT_SS.
- WAIT_SS: ignore MOSI; MISO=0; go to IDLE when SS_n goes high.
- SS_n high in any non-IDLE state:
  - Go to IDLE next edge; MISO=0; any partial frame is discarded.
  - If fewer than DATA_W+2 bits of the current frame had been sampled, frame_err pulses.
  - An in-flight mem_re result is dropped.
- MISO is 0 whenever the block is not in READ_DATA output phase.
- At most one of mem_we and mem_re is high in any cycle.

Test Plan:
- Reset: hold rst_n low 2 cycles while toggling SS_n and MOSI -> MISO, mem_we, mem_re, frame_err all 0; first frame after release decodes normally.
- Single write: mode 0 + 00_0x05, SS_n high, then mode 0 + 01_0x25 -> exactly one mem_we cycle with mem_addr=0x05, mem_wdata=0x25.
- Burst write with wrap: address frame 0xFE, then 01_0xA1 followed by 0xB2 and 0xC3 under one SS_n -> writes FE=A1, FF=B2, 00=C3, each mem_we one cycle.
- Burst read: preload mem[05]=0x25 and mem[06]=0x3C; send read-address 10_0x05, then 11_0x00 and hold SS_n for 16 extra edges -> mem_re at 05 on edge N; MISO=00100101 from N+2, then 00111100 with no gap; mem_re seen at 06 and 07.
- Bad command: mode 0 + 11_0x12 -> frame_err one cycle, no mem_we, no mem_re; after SS_n high, next valid write succeeds.
- Abort: SS_n rises after 5 bits of a 01 frame -> frame_err pulse, no mem_we. Also assert rst_n mid-burst-read -> MISO=0 and addr_loaded cleared on the next edge.
